alu_exec_unit: RTL and testbench

Parametrised successor to the combinational ALU control decoder. Decodes ALUOp/funct3/funct7 internally and executes the full RV32I ALU set at width XLEN, including SLTU and SRA, which the previous decoder could not express. Results go through a one-entry registered output stage with a valid/ready handshake. The optional M-extension path adds an iterative multiplier. Sits between the register-read stage and writeback in the multi-cycle core.

---
 rtl/alu_exec_unit_if.sv | 32 +++
 rtl/alu_exec_unit.sv | 181 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Operation/result bus for alu_exec_unit: operand offer, registered result and status.
// The unit is the slave; the register-read/writeback side is the master.
interface alu_exec_unit_if #(
  parameter int XLEN = 32
) ();
  // Both directions use valid/ready: a transfer happens on the rising edge
  // where valid && ready. A producer holds its payload while valid && !ready.
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            op5;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;
  logic            dbg_state;

  modport slave (
    input  in_valid, alu_op, funct3, funct7, op5, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, busy, dbg_state
  );

  modport master (
    output in_valid, alu_op, funct3, funct7, op5, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, busy, dbg_state
  );
endinterface

// File: rtl/alu_exec_unit.sv
// RV32I ALU execute stage with one-entry registered result and valid/ready handshake.
// Define RV_MUL_EN to build the iterative MUL/MULHU path (shift-add, XLEN+1 cycle latency).
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input logic             clk,
  input logic             rst,
  alu_exec_unit_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL,
    OP_SRA, OP_OR, OP_AND, OP_ZERO, OP_MUL, OP_MULHU
  } op_t;

  state_t          state;
  op_t             op;
  logic            m_sel;
  logic            accept;
  logic            in_ready_c;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            out_valid_q;

  assign shamt      = bus.src_b[SHW-1:0];
  assign in_ready_c = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;

`ifdef RV_MUL_EN
  assign m_sel = (bus.alu_op == 2'b10) && bus.op5 && (bus.funct7 == 7'b0000001);
`else
  // Without the M path, funct7=0000001 is just a base encoding with funct7[5]=0.
  assign m_sel = 1'b0;
  logic unused_funct7;
  assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};
`endif

  // Operation decode
  always_comb begin
    op = OP_ADD;
    case (bus.alu_op)
      2'b01: op = OP_SUB;
      2'b10: begin
        if (m_sel) begin
          case (bus.funct3)
            3'b000:  op = OP_MUL;
            3'b011:  op = OP_MULHU;
            default: op = OP_ZERO;
          endcase
        end else begin
          case (bus.funct3)
            3'b000:  op = (bus.op5 && bus.funct7[5]) ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = bus.funct7[5] ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
          endcase
        end
      end
      default: op = OP_ADD;
    endcase
  end

  // Single-cycle datapath
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = bus.src_a + bus.src_b;
      OP_SUB:  alu_res = bus.src_a - bus.src_b;
      OP_SLL:  alu_res = bus.src_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.src_a < bus.src_b)};
      OP_XOR:  alu_res = bus.src_a ^ bus.src_b;
      OP_SRL:  alu_res = bus.src_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.src_a) >>> shamt);
      OP_OR:   alu_res = bus.src_a | bus.src_b;
      OP_AND:  alu_res = bus.src_a & bus.src_b;
      default: alu_res = '0;
    endcase
  end

`ifdef RV_MUL_EN
  localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

  state_t            state_d;
  logic              is_mul;
  logic              mul_done;
  logic [SHW-1:0]    cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN:0]     psum;
  logic [XLEN-1:0]   mcand_q;
  logic              mhi_q;
  logic [XLEN-1:0]   mul_res;

  assign is_mul   = (op == OP_MUL) || (op == OP_MULHU);
  assign mul_done = (state == MUL) && (cnt_q == LAST);

  // Upper half accumulates the multiplicand when the current multiplier bit
  // (acc[0]) is set; the whole accumulator then shifts right by one.
  assign psum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_nxt = {psum, acc_q[XLEN-1:1]};
  assign mul_res = mhi_q ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept && is_mul) state_d = MUL;
      MUL:     if (cnt_q == LAST)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mhi_q   <= 1'b0;
    end else if (accept && is_mul) begin
      cnt_q   <= '0;
      acc_q   <= {{XLEN{1'b0}}, bus.src_b};
      mcand_q <= bus.src_a;
      mhi_q   <= (op == OP_MULHU);
    end else if (state == MUL) begin
      cnt_q   <= cnt_q + 1'b1;
      acc_q   <= acc_nxt;
    end
  end
`else
  logic            is_mul;
  logic            mul_done;
  logic [XLEN-1:0] mul_res;

  assign state    = IDLE;
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
`endif

  // Result register: loads on a single-cycle accept or on multiply completion,
  // otherwise holds; out_valid drops on a drain that is not refilled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      if (accept && !is_mul) begin
        out_valid_q <= 1'b1;
        result_q    <= alu_res;
        zero_q      <= (alu_res == '0);
      end else if (mul_done) begin
        out_valid_q <= 1'b1;
        result_q    <= mul_res;
        zero_q      <= (mul_res == '0);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = (state == MUL);
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: decode table, handshake hold/back-to-back,
// multiply path (when RV_MUL_EN is defined) and asynchronous reset abort.
module tb_alu_exec_unit;
  localparam int XLEN = 32;
`ifdef RV_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.XLEN(XLEN)) bus ();

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int              n_checks = 0;
  int              n_errors = 0;
  logic [XLEN-1:0] exp_q[$];
  string           tag_q[$];

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every completed output transfer is matched against the queue.
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", XLEN'(exp_q.size()), XLEN'(1));
      end else begin
        logic [XLEN-1:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({"res_", t}, bus.result, e);
        check({"zero_", t}, XLEN'(bus.zero), XLEN'(e == '0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input string tag, input logic [1:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic o5,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp);
    bus.alu_op   = op;
    bus.funct3   = f3;
    bus.funct7   = f7;
    bus.op5      = o5;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.in_valid = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic wait_accept(input string tag, output int waits);
    logic rdy;
    rdy   = 1'b0;
    waits = 0;
    while (!rdy && waits < 200) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      waits++;
    end
    check({"accept_", tag}, XLEN'(rdy), XLEN'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic o5,
                     input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [XLEN-1:0] exp);
    int w;
    drive(tag, op, f3, f7, o5, a, b, exp);
    wait_accept(tag, w);
  endtask

  task automatic wait_valid(output int cyc, output int busy_cyc, output logic st1);
    cyc      = 0;
    busy_cyc = 0;
    st1      = 1'b0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) st1 = bus.dbg_state;
      if (bus.busy) busy_cyc++;
      if (bus.out_valid) break;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   w;
    int   cyc;
    int   bcyc;
    logic st1;

    bus.in_valid  = 1'b0;
    bus.alu_op    = 2'b00;
    bus.funct3    = 3'b000;
    bus.funct7    = 7'b0;
    bus.op5       = 1'b0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", XLEN'(bus.out_valid), XLEN'(0));
    check("rst_result", bus.result, XLEN'(0));
    check("rst_zero", XLEN'(bus.zero), XLEN'(0));
    check("rst_busy", XLEN'(bus.busy), XLEN'(0));
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", XLEN'(bus.in_ready), XLEN'(1));
    @(posedge clk);
    #1;

    // Decode table, issued back-to-back at full rate.
    run("sub_r",  2'b10, 3'b000, 7'h20, 1'b1, 32'd5,        32'd7,        32'hFFFF_FFFE);
    run("add_i",  2'b10, 3'b000, 7'h20, 1'b0, 32'd5,        32'd7,        32'h0000_000C);
    run("sra",    2'b10, 3'b101, 7'h20, 1'b1, 32'h8000_0000, 32'd4,       32'hF800_0000);
    run("srl",    2'b10, 3'b101, 7'h00, 1'b1, 32'h8000_0000, 32'd4,       32'h0800_0000);
    run("srai",   2'b10, 3'b101, 7'h20, 1'b0, 32'h8000_0000, 32'h404,     32'hF800_0000);
    run("beq",    2'b01, 3'b000, 7'h00, 1'b0, 32'd9,        32'd9,        32'h0000_0000);
    run("slt",    2'b10, 3'b010, 7'h00, 1'b1, 32'hFFFF_FFFF, 32'd1,       32'h0000_0001);
    run("sltu",   2'b10, 3'b011, 7'h00, 1'b1, 32'hFFFF_FFFF, 32'd1,       32'h0000_0000);
    run("sll",    2'b10, 3'b001, 7'h00, 1'b1, 32'd1,        32'h3F,       32'h8000_0000);
    run("xor",    2'b10, 3'b100, 7'h00, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    run("or",     2'b10, 3'b110, 7'h00, 1'b1, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0);
    run("and",    2'b10, 3'b111, 7'h00, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    run("ld_wrap",2'b00, 3'b111, 7'h20, 1'b1, 32'hFFFF_FFFF, 32'd1,       32'h0000_0000);
    run("add_11", 2'b11, 3'b100, 7'h20, 1'b1, 32'd7,        32'd8,        32'h0000_000F);
    repeat (2) @(posedge clk);
    #1;

    // Consumer stall: result holds and no new op is accepted until drained.
    bus.out_ready = 1'b0;
    run("hold_a", 2'b10, 3'b000, 7'h00, 1'b1, 32'd100, 32'd23, 32'd123);
    drive("hold_b", 2'b10, 3'b000, 7'h00, 1'b1, 32'd1, 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_in_ready", XLEN'(bus.in_ready), XLEN'(0));
      check("hold_out_valid", XLEN'(bus.out_valid), XLEN'(1));
      check("hold_result", bus.result, XLEN'(123));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    wait_accept("hold_b", w);
    check("b2b_same_edge", XLEN'(w), XLEN'(1));
    @(negedge clk);
    check("b2b_out_valid", XLEN'(bus.out_valid), XLEN'(1));
    @(posedge clk);
    #1;

    // M-extension encodings (base decode when the multiplier is not built).
    run("mul_lo", 2'b10, 3'b000, 7'h01, 1'b1, 32'hFFFF_FFFF, 32'd2,
        MUL_EN ? 32'hFFFF_FFFE : 32'h0000_0001);
    wait_valid(cyc, bcyc, st1);
    check("mul_latency", XLEN'(cyc), MUL_EN ? XLEN'(33) : XLEN'(1));
    check("mul_busy_cycles", XLEN'(bcyc), MUL_EN ? XLEN'(32) : XLEN'(0));
    check("mul_dbg_state", XLEN'(st1), MUL_EN ? XLEN'(1) : XLEN'(0));
    run("mulhu", 2'b10, 3'b011, 7'h01, 1'b1, 32'hFFFF_FFFF, 32'd2,
        MUL_EN ? 32'h0000_0001 : 32'h0000_0000);
    wait_valid(cyc, bcyc, st1);
    run("mul_small", 2'b10, 3'b000, 7'h01, 1'b1, 32'd6, 32'd7,
        MUL_EN ? 32'd42 : 32'd13);
    wait_valid(cyc, bcyc, st1);
    run("mulhu_b", 2'b10, 3'b011, 7'h01, 1'b1, 32'd3, 32'h8000_0000,
        MUL_EN ? 32'h0000_0001 : 32'h0000_0001);
    wait_valid(cyc, bcyc, st1);
    run("m_undef", 2'b10, 3'b100, 7'h01, 1'b1, 32'hF0, 32'h0F,
        MUL_EN ? 32'h0000_0000 : 32'h0000_00FF);
    wait_valid(cyc, bcyc, st1);
    check("m_undef_latency", XLEN'(cyc), XLEN'(1));

    // Asynchronous reset in the middle of a multiply.
    run("mul_abort", 2'b10, 3'b000, 7'h01, 1'b1, 32'd12345, 32'd2,
        MUL_EN ? 32'd24690 : 32'd12347);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    tag_q.delete();
    #1;
    check("abort_out_valid", XLEN'(bus.out_valid), XLEN'(0));
    check("abort_busy", XLEN'(bus.busy), XLEN'(0));
    check("abort_state", XLEN'(bus.dbg_state), XLEN'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", XLEN'(bus.in_ready), XLEN'(1));
    @(posedge clk);
    #1;
    run("add_post_rst", 2'b00, 3'b000, 7'h00, 1'b0, 32'd2, 32'd3, 32'd5);

    repeat (5) @(negedge clk);
    check("sb_drain", XLEN'(exp_q.size()), XLEN'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
